// File: rtl/oam_dma.sv
// NES sprite DMA: a CPU write to TRIGGER_ADDR copies one 256-byte page into PPU OAM.
// Define OAM_DMA_ALIGN_EN to start reads on even cycles (inserts one ALIGN cycle when needed).
module oam_dma #(
    parameter logic [15:0] TRIGGER_ADDR = 16'h4014,
    parameter int unsigned XFER_LEN     = 256
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic        cpu_w,
    input  logic [15:0] cpu_address,
    input  logic [7:0]  cpu_data,
    input  logic [7:0]  mem_out,
    output logic        dma_active,
    output logic [15:0] mem_address,
    output logic        mem_r,
    output logic        oam_w,
    output logic [7:0]  oam_address,
    output logic [7:0]  oam_data,
    output logic        done
);

    localparam logic [7:0] LAST_IDX = 8'(XFER_LEN - 1);

    typedef enum logic [2:0] {
        IDLE,
        HALT,
        ALIGN,
        READ,
        WRITE
    } state_t;

    state_t     state;
    state_t     state_nx;
    logic [7:0] page;
    logic [7:0] index;
    logic [7:0] data_reg;
    logic       done_q;
    logic       trigger;
    logic       last;

    assign trigger = cpu_w && (cpu_address == TRIGGER_ADDR);
    assign last    = (index == LAST_IDX);

`ifdef OAM_DMA_ALIGN_EN
    // Free-running cycle parity; zero on the first cycle after reset.
    logic parity;

    always_ff @(posedge CLK) begin
        if (Reset) parity <= 1'b0;
        else       parity <= ~parity;
    end
`endif

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (trigger) state_nx = HALT;
`ifdef OAM_DMA_ALIGN_EN
            HALT:    state_nx = parity ? READ : ALIGN;
`else
            HALT:    state_nx = READ;
`endif
            ALIGN:   state_nx = READ;
            READ:    state_nx = WRITE;
            WRITE:   state_nx = last ? IDLE : READ;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state    <= IDLE;
            page     <= '0;
            index    <= '0;
            data_reg <= '0;
            done_q   <= 1'b0;
        end else begin
            state  <= state_nx;
            done_q <= (state == WRITE) && last;
            case (state)
                IDLE: begin
                    if (trigger) begin
                        page  <= cpu_data;
                        index <= '0;
                    end
                end
                READ:    data_reg <= mem_out;
                WRITE:   if (!last) index <= index + 8'd1;
                default: ;
            endcase
        end
    end

    // Bus outputs are held at zero outside their own state.
    always_comb begin
        dma_active  = (state != IDLE);
        mem_r       = (state == READ);
        oam_w       = (state == WRITE);
        mem_address = mem_r ? {page, index} : 16'h0000;
        oam_address = oam_w ? index : 8'h00;
        oam_data    = oam_w ? data_reg : 8'h00;
        done        = done_q;
    end

endmodule

// File: doc/oam_dma.md
Name: oam_dma

Overview:
- Bus initiator that performs NES sprite DMA. A CPU write to $4014 triggers it.
- Stalls the 6502 core, then reads 256 bytes from CPU address space (page N×256 .. N×256+255) through the second master port of the CPU memory. Each byte goes to PPU OAM in the following cycle.
- Sits between the CPU bus decode, `cpu_memory`, and the PPU OAM RAM.

Parameters:
- TRIGGER_ADDR, 16'h4014: CPU write address that starts a transfer.
- XFER_LEN, 256: bytes per transfer. Must be ≤256; the index is 8 bits.

Ports:
- CLK  input  1  system clock; all state changes on posedge.
- Reset  input  1  synchronous, active-high reset.
- cpu_w  input  1  CPU write strobe for this cycle.
- cpu_address  input  16  CPU bus address.
- cpu_data  input  8  CPU write data; page number when triggering.
- mem_out  input  8  read data from CPU memory. Valid at the posedge ending the cycle in which mem_address/mem_r were driven.
- dma_active  output  1  CPU stall; high from HALT through the last WRITE.
- mem_address  output  16  DMA read address = {page, index}.
- mem_r  output  1  DMA read strobe.
- oam_w  output  1  OAM write strobe.
- oam_address  output  8  OAM byte address = index.
- oam_data  output  8  byte captured in the preceding READ.
- done  output  1  one-cycle pulse after the transfer completes.

Behaviour:
- **Outputs:** all are Moore decodes of registered state/regs. Reset value is 0 for every output. Reset also forces state IDLE, index=0, page=0, data_reg=0, parity=0.
- **parity:** free-running bit, toggles every cycle. Reset to 0, so the first cycle after reset is even.
- **States:** IDLE, HALT, ALIGN, READ, WRITE.
- **IDLE:**
  - At a posedge with cpu_w=1 and cpu_address==TRIGGER_ADDR: page<=cpu_data, index<=0, next state HALT.
  - Otherwise stay in IDLE.
  - done=1 only on the first IDLE cycle after the final WRITE.
- **HALT:** dma_active=1, no bus activity. Exactly one cycle. Next is ALIGN or READ; see Optional Feature.
- **ALIGN:** dma_active=1, no bus activity. One cycle, then READ.
- **READ:**
  - Drives mem_r=1 and mem_address={page,index}.
  - At the posedge, data_reg<=mem_out.
  - Next state WRITE.
- **WRITE:**
  - Drives oam_w=1, oam_address=index, oam_data=data_reg.
  - If index==XFER_LEN-1: next state IDLE with done pulse.
  - Otherwise index<=index+1, next state READ.
- **Timing:**
  - Transfer length in cycles = 1 (HALT) + align + 2×XFER_LEN, i.e. 513 or 514 for 256 bytes.
  - First trigger-to-dma_active latency is 1 cycle, since dma_active rises in the cycle after the trigger write.
- **Address width:** mem_address never carries past the page boundary; the index is 8 bits. Page $FF reads $FF00–$FFFF.
- **Page $00–$1F:** addresses are issued unmirrored; the memory applies its own mirroring.
- **Triggers while busy:** cpu_w to TRIGGER_ADDR in any non-IDLE state is ignored, including the done cycle's predecessor. page is not overwritten.
- **Back-to-back trigger:** a trigger on the done cycle (IDLE) is accepted normally.
- **Reset mid-transfer:** next cycle is IDLE with all outputs 0. No done pulse. The partial OAM contents are left as written.
- **Non-trigger writes:** cpu_w to other addresses is ignored in all states.

Optional Feature:
- Macro: OAM_DMA_ALIGN_EN.
- **Defined:**
  - READ must begin on an even cycle (parity==0).
  - If parity in HALT is 0, the next cycle is odd, so ALIGN is inserted (514 cycles total).
  - If parity in HALT is 1, HALT goes straight to READ (513 cycles total).
- **Undefined:** ALIGN is never entered; HALT always goes to READ; every transfer is exactly 513 cycles. The parity register may be removed.

Test Plan:
- **Basic transfer:** memory $0200+i preloaded with i^8'hA5; reset, then write $02 to $4014 → 256 OAM writes with oam_address=i, oam_data=i^A5. done pulses once. dma_active is high for 513/514 cycles and low the cycle done rises.
- **Alignment (macro defined):** trigger with HALT landing on parity 0 → exactly one ALIGN cycle, first mem_r on an even cycle, 514 stall cycles. Repeat with HALT on parity 1 → 513 cycles. Macro undefined → 513 in both cases.
- **Retrigger while busy:** write $07 to $4014 while dma_active=1 → ignored. All 256 reads stay within $02xx. A trigger in the done cycle with $03 → a second transfer from $0300.
- **Reset mid-transfer:** assert Reset at index=$40 during WRITE → next cycle all outputs 0, state IDLE, no done. A new trigger with $05 restarts at $0500, oam_address=0.
- **Page wrap:** trigger with $FF → last read at $FFFF, index wraps to IDLE, no access at $0000.
- **Decode qualification:** cpu_w=1 to $4015 and $2014, and cpu_w=0 with address $4014 → no transfer started, dma_active stays 0.
